// File: rtl/gf2_poly_div_81by41_if.sv
// rtl/gf2_poly_div_81by41_if.sv - operand/result handshake bundle for the GF(2) divider
interface gf2_poly_div_81by41_if #(
  parameter int N = 41,
  parameter int M = 2*N-1
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  // Producer/consumer side: supplies operands, accepts results.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/gf2_poly_div_81by41.sv
// rtl/gf2_poly_div_81by41.sv - sequential GF(2)[x] long divider, one quotient bit per clock
module gf2_poly_div_81by41 #(
  parameter int N = 41,
  parameter int M = 2*N-1
) (
  input  logic                  clk,
  input  logic                  rst,
  gf2_poly_div_81by41_if.slave  bus
);
  localparam int CW = $clog2(M);
  localparam int DW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(M-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  // Dividend is kept as a left-shifting register so the next bit to bring
  // down is always the MSB; this avoids a wide variable bit select.
  logic [M-1:0]  dvd, dvd_nxt;
  logic [N-1:0]  dvs, dvs_nxt;
  logic [DW-1:0] d, d_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [M-1:0]  q, q_nxt;
  logic [N-1:0]  r, r_nxt;
  logic          dz, dz_nxt;
  logic [N-1:0]  r_sh;
  logic [DW-1:0] msb_idx;

  // Position of the highest set bit of the latched divisor (degree of b).
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (dvs[i]) msb_idx = DW'(i);
    end
  end

  // Next-state and datapath update; every target defaults to holding.
  always_comb begin
    state_nxt = state;
    dvd_nxt   = dvd;
    dvs_nxt   = dvs;
    d_nxt     = d;
    count_nxt = count;
    q_nxt     = q;
    r_nxt     = r;
    dz_nxt    = dz;
    // Bits of r at or above d are always zero here, so dropping r[N-1]
    // never loses information.
    r_sh      = {r[N-2:0], dvd[M-1]};
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_nxt   = bus.dividend;
          dvs_nxt   = bus.divisor;
          dz_nxt    = 1'b0;
          state_nxt = NORM;
        end
      end
      NORM: begin
        q_nxt     = '0;
        r_nxt     = '0;
        count_nxt = '0;
        if (dvs == '0) begin
          dz_nxt    = 1'b1;
          state_nxt = DONE;
        end else begin
          d_nxt     = msb_idx;
          state_nxt = DIV;
        end
      end
      DIV: begin
        if (r_sh[d]) begin
          r_nxt = r_sh ^ dvs;
          q_nxt = {q[M-2:0], 1'b1};
        end else begin
          r_nxt = r_sh;
          q_nxt = {q[M-2:0], 1'b0};
        end
        dvd_nxt = {dvd[M-2:0], 1'b0};
        // count saturates at M-1 rather than wrapping.
        if (count == LAST) begin
          state_nxt = DONE;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      d     <= '0;
      count <= '0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
    end else begin
      state <= state_nxt;
      dvd   <= dvd_nxt;
      dvs   <= dvs_nxt;
      d     <= d_nxt;
      count <= count_nxt;
      q     <= q_nxt;
      r     <= r_nxt;
      dz    <= dz_nxt;
    end
  end

  // Handshake flags are straight decodes of the state register.
  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = q;
  assign bus.remainder   = r;
  assign bus.div_by_zero = dz;
endmodule
